cassette_rec: RTL and testbench

CASSETTE_REC -- requirements
Module: cassette_rec

---
 rtl/cassette_pkg.sv | 21 ++
 rtl/cassette_rec_if.sv | 24 ++
 rtl/tape_period_meter.sv | 64 ++++++
 rtl/cassette_rec.sv | 133 +++++++++++++
 tb/tb_cassette_rec.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cassette_pkg.sv
// Shared cassette definitions: recorder/playback state encoding and default timing.
// Timing constants are in 4 MHz clock cycles.
package cassette_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HUNT  = 2'd2,
    ST_BYTE  = 2'd3
  } tape_state_e;

  localparam int unsigned DEF_THRESH  = 2500;
  localparam int unsigned DEF_MIN_PER = 600;
  localparam int unsigned DEF_TIMEOUT = 8000;

  localparam int unsigned PER_W  = 13;
  localparam int unsigned ADDR_W = 25;

  localparam logic [7:0] SYNC_BYTE = 8'h3C;

endpackage

// File: rtl/cassette_rec_if.sv
// Byte-write request port between the cassette recorder and the SDRAM writer.
interface cassette_rec_if;
  import cassette_pkg::*;

  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_data;
  logic              sdram_wr;
  logic              sdram_ack;

  modport master (
    output sdram_addr,
    output sdram_data,
    output sdram_wr,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr,
    input  sdram_data,
    input  sdram_wr,
    output sdram_ack
  );

endinterface

// File: rtl/tape_period_meter.sv
// Synchronizes the cassette line, measures rise-to-rise periods and classifies
// each accepted period as a 1 (short) or 0 (long) bit; flags line silence.
module tape_period_meter
  import cassette_pkg::*;
#(
  parameter int unsigned THRESH  = DEF_THRESH,
  parameter int unsigned MIN_PER = DEF_MIN_PER,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic cout_i,
  output logic edge_o,
  output logic bit_valid_o,
  output logic bit_value_o,
  output logic silence_o
);

  localparam logic [PER_W-1:0] MIN_V = PER_W'(MIN_PER);
  localparam logic [PER_W-1:0] THR_V = PER_W'(THRESH);
  localparam logic [PER_W-1:0] TO_V  = PER_W'(TIMEOUT);

  logic             sync1_q, sync2_q, prev_q;
  logic [PER_W-1:0] per_q;
  logic             edge_q, bit_valid_q, bit_value_q, silence_q;
  logic             rise, accept;

  assign rise   = sync2_q & ~prev_q;
  // Edges arriving too soon after the last accepted one are glitches and
  // leave the running period untouched.
  assign accept = rise && (per_q >= MIN_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      per_q       <= '0;
      edge_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      silence_q   <= 1'b0;
    end else begin
      sync1_q     <= cout_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      edge_q      <= accept;
      bit_valid_q <= accept && (per_q < TO_V);
      bit_value_q <= per_q < THR_V;
      silence_q   <= !accept && (per_q == TO_V - PER_W'(1));
      if (accept) begin
        per_q <= '0;
      end else if (per_q != TO_V) begin
        per_q <= per_q + PER_W'(1);
      end
    end
  end

  assign edge_o      = edge_q;
  assign bit_valid_o = bit_valid_q;
  assign bit_value_o = bit_value_q;
  assign silence_o   = silence_q;

endmodule

// File: rtl/cassette_rec.sv
// MC-10 cassette recorder: decodes the tape bit stream, locks on the 0x3C sync
// byte and streams the following bytes into SDRAM through a held write request.
module cassette_rec
  import cassette_pkg::*;
#(
  parameter int unsigned       THRESH   = DEF_THRESH,
  parameter int unsigned       MIN_PER  = DEF_MIN_PER,
  parameter int unsigned       TIMEOUT  = DEF_TIMEOUT,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 25'h1FFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              rewind,
  input  logic              cout,
  cassette_rec_if.master    bus,
  output logic [ADDR_W-1:0] length,
  output logic [2:0]        status
);

  logic edge_pulse, bit_valid, bit_value, silence;

  tape_period_meter #(
    .THRESH (THRESH),
    .MIN_PER(MIN_PER),
    .TIMEOUT(TIMEOUT)
  ) u_meter (
    .clk        (clk),
    .reset      (reset),
    .cout_i     (cout),
    .edge_o     (edge_pulse),
    .bit_valid_o(bit_valid),
    .bit_value_o(bit_value),
    .silence_o  (silence)
  );

  tape_state_e       state_q;
  logic [7:0]        win_q, win_d, data_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q, len_q;
  logic              wr_q, full_q, ovr_q;
  logic              commit, last_commit, byte_rdy;

  assign win_d       = {bit_value, win_q[7:1]};
  assign commit      = wr_q && bus.sdram_ack;
  assign last_commit = commit && (addr_q == ADDR_MAX);
  assign byte_rdy    = bit_valid &&
                       (((state_q == ST_HUNT) && (win_d == SYNC_BYTE)) ||
                        ((state_q == ST_BYTE) && (cnt_q == 3'd7)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (rewind) begin
      // Rewind aborts any pending write; a coinciding ack is ignored.
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (commit) begin
        wr_q  <= 1'b0;
        len_q <= len_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) begin
          full_q <= 1'b1;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      if (byte_rdy) begin
        if (wr_q) begin
          ovr_q <= 1'b1;
        end else begin
          data_q <= win_d;
          wr_q   <= 1'b1;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (record && !full_q) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (edge_pulse) begin
            state_q <= ST_HUNT;
            win_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ST_HUNT: begin
          if (silence) begin
            state_q <= ST_ARMED;
          end else if (bit_valid) begin
            win_q <= win_d;
            if (win_d == SYNC_BYTE) begin
              state_q <= ST_BYTE;
              cnt_q   <= '0;
            end
          end
        end
        ST_BYTE: begin
          if (silence) begin
            state_q <= ST_ARMED;
            cnt_q   <= '0;
          end else if (bit_valid) begin
            win_q <= win_d;
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (!record || last_commit) state_q <= ST_IDLE;
    end
  end

  assign bus.sdram_addr = addr_q;
  assign bus.sdram_data = data_q;
  assign bus.sdram_wr   = wr_q;
  assign length         = len_q;
  assign status         = {ovr_q, full_q, state_q != ST_IDLE};

endmodule

// File: tb/tb_cassette_rec.sv
// Directed bench for cassette_rec: tape periods scaled by 1/20 so a byte takes
// about 1000 cycles; a bit-level decoder model predicts the committed bytes.
module tb_cassette_rec;
  import cassette_pkg::*;

  localparam int unsigned       TB_THRESH = 125;
  localparam int unsigned       TB_MIN    = 30;
  localparam int unsigned       TB_TO     = 400;
  localparam logic [ADDR_W-1:0] TB_AMAX   = 25'd3;
  localparam int P1 = 83;
  localparam int P0 = 167;

  logic clk = 1'b0, reset = 1'b1, record = 1'b0, rewind = 1'b0, cout = 1'b0;
  logic ack = 1'b0;
  logic [ADDR_W-1:0] length;
  logic [2:0] status;

  cassette_rec_if bus ();
  assign bus.sdram_ack = ack;

  cassette_rec #(
    .THRESH  (TB_THRESH),
    .MIN_PER (TB_MIN),
    .TIMEOUT (TB_TO),
    .ADDR_MAX(TB_AMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .record(record),
    .rewind(rewind),
    .cout  (cout),
    .bus   (bus),
    .length(length),
    .status(status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  bit         m_sync, pend_v, pend_b, m_busy, m_ovr, ack_hold, mon_on;
  logic [7:0] m_win;
  int         m_cnt, m_emitted, model_len;

  function automatic void model_arm();
    m_sync = 0; m_win = 8'h00; m_cnt = 0; pend_v = 0;
  endfunction

  function automatic void model_clear();
    model_arm();
    m_emitted = 0; m_busy = 0; m_ovr = 0;
  endfunction

  function automatic void model_emit(input logic [7:0] b);
    if (m_emitted > int'(TB_AMAX)) return;   // recorder has filled and stopped
    if (m_busy) m_ovr = 1;
    else begin
      exp_q.push_back(b);
      m_emitted++;
      if (ack_hold) m_busy = 1;
    end
  endfunction

  function automatic void model_bit(input bit b);
    m_win = {b, m_win[7:1]};
    if (!m_sync) begin
      if (m_win == 8'h3C) begin
        m_sync = 1; m_cnt = 0; model_emit(m_win);
      end
    end else begin
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0; model_emit(m_win);
      end
    end
  endfunction

  function automatic logic [7:0] logv(input int i);
    return (log_q.size() > i) ? log_q[i] : 8'hxx;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tape cycle: rising edge, high for half the period; the bit it carries is
  // decoded when the next rising edge arrives.
  task automatic send_bit(input bit b, input bit glitch);
    int p;
    p = b ? P1 : P0;
    if (pend_v) model_bit(pend_b);
    pend_v = 1; pend_b = b;
    for (int i = 0; i < p; i++) begin
      @(posedge clk); #1;
      cout = (i < p / 2) && !(glitch && ((i >= 8 && i < 12) || (i >= 16 && i < 20)));
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit glitch);
    for (int i = 0; i < 8; i++) send_bit(v[i], glitch);
  endtask

  task automatic send_tail();
    if (pend_v) model_bit(pend_b);
    pend_v = 0;
    @(posedge clk); #1 cout = 1'b1;
    cycles(20);
    cout = 1'b0;
  endtask

  task automatic quiet(input int n);
    pend_v = 0;
    model_arm();
    cycles(n);
  endtask

  task automatic do_rewind();
    @(posedge clk); #1 rewind = 1'b1;
    @(posedge clk); #1 rewind = 1'b0;
    model_clear();
    cycles(3);
  endtask

  // ---------------- write acknowledger ----------------
  initial begin
    int wr_age;
    wr_age = 0;
    forever begin
      @(posedge clk); #1;
      if (!ack_hold) begin
        if (ack) ack = 1'b0;
        else if (bus.sdram_wr === 1'b1) begin
          wr_age++;
          if (wr_age >= 2) begin ack = 1'b1; wr_age = 0; end
        end else wr_age = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       prev_wr = 1'b0, prev_skip = 1'b1;
  logic [7:0] prev_data = 8'h00;
  logic [ADDR_W-1:0] prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        logic commit;
        chk("length", 32'(length), 32'(model_len));
        chk("addr", 32'(bus.sdram_addr),
            (model_len > int'(TB_AMAX)) ? 32'(TB_AMAX) : 32'(model_len));
        chk("full", 32'(status[1]), 32'(model_len > int'(TB_AMAX)));
        if (prev_wr && !prev_skip) begin
          chk("wr_hold", 32'(bus.sdram_wr), 32'd1);
          chk("data_hold", 32'(bus.sdram_data), 32'(prev_data));
          chk("addr_hold", 32'(bus.sdram_addr), 32'(prev_addr));
        end
        if (bus.sdram_wr && !prev_wr)
          chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        commit = bus.sdram_wr && ack && !rewind && !reset;
        if (commit) begin
          chk("wr_data", 32'(bus.sdram_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hxx);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          log_q.push_back(bus.sdram_data);
          model_len++;
        end
        if (rewind || reset) begin
          model_len = 0;
          exp_q.delete();
          log_q.delete();
        end
        prev_wr   = bus.sdram_wr;
        prev_data = bus.sdram_data;
        prev_addr = bus.sdram_addr;
        prev_skip = commit || rewind || reset;
      end
    end
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    ack_hold = 0; mon_on = 0; model_len = 0;
    model_clear();
    cycles(4);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    chk("rst_data", 32'(bus.sdram_data), 32'd0);
    chk("rst_wr", 32'(bus.sdram_wr), 32'd0);
    chk("rst_len", 32'(length), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    reset = 1'b0;
    mon_on = 1;
    record = 1'b1;
    cycles(5);
    chk("armed_status", 32'(status), 32'b001);

    // leader + sync + data byte
    for (int k = 0; k < 16; k++) send_byte(8'h55, 0);
    send_byte(8'h3C, 0);
    send_byte(8'hA5, 0);
    send_tail();
    quiet(500);
    chk("t1_byte0", 32'(logv(0)), 32'h3C);
    chk("t1_byte1", 32'(logv(1)), 32'hA5);
    chk("t1_len", 32'(length), 32'd2);
    chk("t1_status", 32'(status), 32'b001);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // short glitch pulses inside every bit of a byte
    do_rewind();
    send_byte(8'h55, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h96, 1);
    send_tail();
    quiet(500);
    chk("t2_byte1", 32'(logv(1)), 32'h96);
    chk("t2_len", 32'(length), 32'd2);

    // silence after five bits discards the partial byte, then resync
    do_rewind();
    send_byte(8'h55, 0);
    send_byte(8'h3C, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    quiet(500);
    chk("t3_len_after_silence", 32'(length), 32'd1);
    chk("t3_status_armed", 32'(status), 32'b001);
    send_byte(8'h3C, 0);
    send_byte(8'h42, 0);
    send_tail();
    quiet(500);
    chk("t3_byte1", 32'(logv(1)), 32'h3C);
    chk("t3_byte2", 32'(logv(2)), 32'h42);
    chk("t3_len", 32'(length), 32'd3);

    // ack withheld across two byte completions
    do_rewind();
    ack_hold = 1;
    send_byte(8'h55, 0);
    send_byte(8'h3C, 0);
    send_byte(8'hA5, 0);
    send_tail();
    cycles(100);
    chk("t4_status", 32'(status), 32'b101);
    chk("t4_ovr_model", 32'(status[2]), 32'(m_ovr));
    chk("t4_wr_held", 32'(bus.sdram_wr), 32'd1);
    chk("t4_data_held", 32'(bus.sdram_data), 32'h3C);
    ack_hold = 0; m_busy = 0;
    quiet(500);
    chk("t4_len", 32'(length), 32'd1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // fill to ADDR_MAX
    do_rewind();
    chk("t5_rewind_status", 32'(status), 32'b001);
    send_byte(8'h55, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_tail();
    quiet(500);
    chk("t5_len", 32'(length), 32'd4);
    chk("t5_addr", 32'(bus.sdram_addr), 32'd3);
    chk("t5_status", 32'(status), 32'b010);
    chk("t5_byte3", 32'(logv(3)), 32'h33);
    record = 1'b0;
    do_rewind();
    chk("t5_rw_addr", 32'(bus.sdram_addr), 32'd0);
    chk("t5_rw_status", 32'(status), 32'd0);
    ack_hold = 1;
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    cycles(2);
    chk("t5_stray_ack_len", 32'(length), 32'd0);
    record = 1'b1;
    cycles(3);

    // rewind coinciding with ack
    send_byte(8'h3C, 0);
    send_tail();
    cycles(50);
    chk("t6_wr_before", 32'(bus.sdram_wr), 32'd1);
    @(posedge clk); #1 rewind = 1'b1; ack = 1'b1;
    @(posedge clk); #1 rewind = 1'b0; ack = 1'b0;
    chk("t6_wr", 32'(bus.sdram_wr), 32'd0);
    chk("t6_len", 32'(length), 32'd0);
    chk("t6_addr", 32'(bus.sdram_addr), 32'd0);
    model_clear();
    cycles(3);

    // reset in the middle of a pending write
    send_byte(8'h3C, 0);
    send_tail();
    cycles(50);
    chk("t7_wr_before", 32'(bus.sdram_wr), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t7_wr", 32'(bus.sdram_wr), 32'd0);
    chk("t7_addr", 32'(bus.sdram_addr), 32'd0);
    chk("t7_len", 32'(length), 32'd0);
    chk("t7_status", 32'(status), 32'd0);
    model_clear();
    ack_hold = 0;
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
